// File: rtl/block_cache_mp_pkg.sv
// block_cache_mp_pkg: shared block types and helpers for block_cache_mp.
// Holds BlockPos/BlockType, the line index hash and a saturating counter add.
package block_cache_mp_pkg;

    localparam int MAX_CACHE_PORTS = 8;
    localparam int COORD_W = 8;
    localparam int TYPE_W = 8;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } BlockPos;

    typedef logic [TYPE_W-1:0] BlockType;

    typedef enum logic [1:0] {
        FILL_IDLE  = 2'd0,
        FILL_ISSUE = 2'd1,
        FILL_WAIT  = 2'd2
    } fill_state_e;

    // XOR-fold of the coordinates, masked down to idx_w bits
    function automatic logic [COORD_W-1:0] block_index(
        input BlockPos pos,
        input int      idx_w
    );
        logic [COORD_W-1:0] mask;
        mask = (COORD_W'(1) << idx_w) - COORD_W'(1);
        return (pos.x ^ pos.y ^ pos.z) & mask;
    endfunction

    function automatic logic [31:0] sat_add(
        input logic [31:0]                acc,
        input logic [MAX_CACHE_PORTS-1:0] evt
    );
        logic [32:0] sum;
        sum = {1'b0, acc} + 33'($countones(evt));
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/block_cache_mp_rr_arbiter.sv
// rr_arbiter: round-robin pick of the lowest requester at or after rr.
// rr moves one past the winner whenever advance is high with a request.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [N-1:0]                     req,
    input  logic                             advance,
    output logic [N-1:0]                     grant,
    output logic [$clog2(N > 1 ? N : 2)-1:0] grant_idx
);
    localparam int IW = $clog2(N > 1 ? N : 2);
    localparam int SW = IW + 1;

    logic [IW-1:0] rr;
    logic [IW-1:0] cand;
    logic [SW-1:0] sum;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, rr} + SW'(i);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            cand = sum[IW-1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr <= '0;
        end else if (advance && |req) begin
            rr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/block_cache_mp.sv
// block_cache_mp: multi-port direct-mapped BlockPos -> BlockType cache.
// Optional hit/miss counters are enabled by BLOCK_CACHE_MP_STATS_EN.
module block_cache_mp
    import block_cache_mp_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int NUM_LINES = 64
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic     [NUM_PORTS-1:0]       req_valid,
    input  BlockPos  [NUM_PORTS-1:0]       req_pos,
    output logic     [NUM_PORTS-1:0]       rsp_valid,
    output BlockType [NUM_PORTS-1:0]       rsp_type,
    output logic                           fill_req_valid,
    input  logic                           fill_req_ready,
    output BlockPos                        fill_req_pos,
    input  logic                           fill_rsp_valid,
    input  BlockType                       fill_rsp_type
`ifdef BLOCK_CACHE_MP_STATS_EN
    ,
    output logic     [31:0]                hit_count,
    output logic     [31:0]                miss_count
`endif
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int GW = $clog2(NUM_PORTS > 1 ? NUM_PORTS : 2);

    logic [NUM_LINES-1:0] line_valid;
    BlockPos              line_tag  [NUM_LINES];
    BlockType             line_data [NUM_LINES];

    fill_state_e state, state_next;

    logic [NUM_PORTS-1:0] pending;
    logic [NUM_PORTS-1:0] accept;
    logic [NUM_PORTS-1:0] hit;
    logic [NUM_PORTS-1:0] miss;
    logic [NUM_PORTS-1:0] fwd;
    logic [NUM_PORTS-1:0] grant;
    logic [GW-1:0]        grant_idx;
    logic [IDX_W-1:0]     port_idx [NUM_PORTS];
    logic [IDX_W-1:0]     fill_idx;
    logic                 fill_done;
    logic                 arb_advance;

    rr_arbiter #(
        .N(NUM_PORTS)
    ) u_arb (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .req       (pending),
        .advance   (arb_advance),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        fill_idx = IDX_W'(block_index(fill_req_pos, IDX_W));
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_idx[p] = IDX_W'(block_index(req_pos[p], IDX_W));
        end
    end

    // A port is idle only while not pending and not in its response cycle
    assign accept = req_valid & ~pending & ~rsp_valid;

    always_comb begin
        hit  = '0;
        miss = '0;
        fwd  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            hit[p]  = accept[p] && line_valid[port_idx[p]]
                      && (line_tag[port_idx[p]] == req_pos[p]);
            miss[p] = accept[p] && !hit[p];
            fwd[p]  = fill_done && (pending[p] || miss[p])
                      && (req_pos[p] == fill_req_pos);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending   <= '0;
            rsp_valid <= '0;
            rsp_type  <= '0;
        end else begin
            rsp_valid <= hit | fwd;
            pending   <= (pending | miss) & ~fwd;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (fwd[p]) begin
                    rsp_type[p] <= fill_rsp_type;
                end else if (hit[p]) begin
                    rsp_type[p] <= line_data[port_idx[p]];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= FILL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FILL_IDLE:  if (|grant) state_next = FILL_ISSUE;
            FILL_ISSUE: if (fill_req_ready) state_next = FILL_WAIT;
            FILL_WAIT:  if (fill_rsp_valid) state_next = FILL_IDLE;
            default:    state_next = FILL_IDLE;
        endcase
    end

    always_comb begin
        fill_req_valid = (state == FILL_ISSUE);
        arb_advance    = (state == FILL_IDLE);
        fill_done      = (state == FILL_WAIT) && fill_rsp_valid;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fill_req_pos <= '0;
        end else if (arb_advance && |grant) begin
            fill_req_pos <= req_pos[grant_idx];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            line_valid <= '0;
        end else if (fill_done) begin
            line_valid[fill_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset; line_valid gates every use
    always_ff @(posedge clk_in) begin
        if (fill_done) begin
            line_tag[fill_idx]  <= fill_req_pos;
            line_data[fill_idx] <= fill_rsp_type;
        end
    end

`ifdef BLOCK_CACHE_MP_STATS_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            hit_count  <= sat_add(hit_count, MAX_CACHE_PORTS'(hit));
            miss_count <= sat_add(miss_count, MAX_CACHE_PORTS'(miss));
        end
    end
`endif

endmodule

// File: tb/tb_block_cache_mp.sv
// tb_block_cache_mp: directed vector bench for block_cache_mp.
// Table-driven lookups plus shared-miss, conflict and reset sequences.
module tb_block_cache_mp;
    import block_cache_mp_pkg::*;

    localparam int NP = 4;

    logic               clk = 1'b0;
    logic               rst_in;
    logic     [NP-1:0]  req_valid;
    BlockPos  [NP-1:0]  req_pos;
    logic     [NP-1:0]  rsp_valid;
    BlockType [NP-1:0]  rsp_type;
    logic               fill_req_valid;
    logic               fill_req_ready;
    BlockPos            fill_req_pos;
    logic               fill_rsp_valid;
    BlockType           fill_rsp_type;
`ifdef BLOCK_CACHE_MP_STATS_EN
    logic [31:0]        hit_count;
    logic [31:0]        miss_count;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int fill_issues = 0;

    always #5 clk = ~clk;

    block_cache_mp #(
        .NUM_PORTS(NP),
        .NUM_LINES(64)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .req_valid      (req_valid),
        .req_pos        (req_pos),
        .rsp_valid      (rsp_valid),
        .rsp_type       (rsp_type),
        .fill_req_valid (fill_req_valid),
        .fill_req_ready (fill_req_ready),
        .fill_req_pos   (fill_req_pos),
        .fill_rsp_valid (fill_rsp_valid),
        .fill_rsp_type  (fill_rsp_type)
`ifdef BLOCK_CACHE_MP_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    typedef struct {
        int       port;
        BlockPos  pos;
        logic     miss;
        BlockType t;
    } vec_t;

    vec_t vecs[9];

    function automatic BlockPos mkpos(input int x, input int y, input int z);
        BlockPos p;
        p.x = 8'(x);
        p.y = 8'(y);
        p.z = 8'(z);
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fill_req_valid && fill_req_ready) fill_issues++;
    end

    // A held request must keep its position until its response pulse
    logic    [NP-1:0] rsp_seen = '0;
    logic    [NP-1:0] prev_req = '0;
    BlockPos [NP-1:0] prev_pos;
    always @(negedge clk) rsp_seen = rsp_valid;
    always @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (prev_req[p] && !rsp_seen[p] && req_valid[p] && !rst_in)
                check("req_pos_stable", req_pos[p], prev_pos[p]);
        end
        prev_req = req_valid;
        prev_pos = req_pos;
    end

    task automatic serve_fill(input BlockType t, input int delay,
                              output BlockPos got);
        int n;
        n = 0;
        got = '0;
        while (!fill_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fill_req_seen", fill_req_valid, 1);
        if (!fill_req_valid) return;
        got = fill_req_pos;
        @(negedge clk);
        repeat (delay) @(negedge clk);
        fill_rsp_valid = 1'b1;
        fill_rsp_type  = t;
        @(negedge clk);
        fill_rsp_valid = 1'b0;
    endtask

    task automatic do_lookup(input vec_t v);
        BlockPos got;
        int base;
        base = fill_issues;
        req_pos[v.port]   = v.pos;
        req_valid[v.port] = 1'b1;
        @(negedge clk);
        if (v.miss) begin
            check("miss_no_early_rsp", rsp_valid[v.port], 0);
            serve_fill(v.t, 3, got);
            check("fill_pos", got, v.pos);
        end
        check("rsp_valid", rsp_valid[v.port], 1);
        check("rsp_type", rsp_type[v.port], v.t);
        req_valid[v.port] = 1'b0;
        @(negedge clk);
        #1 check("fill_count", fill_issues - base, v.miss ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        BlockPos got;
        BlockPos p;
        int base;

        vecs[0] = '{0, mkpos(3, 5, 7), 1'b1, 8'h2A};
        vecs[1] = '{0, mkpos(3, 5, 7), 1'b0, 8'h2A};
        vecs[2] = '{2, mkpos(3, 5, 7), 1'b0, 8'h2A};
        vecs[3] = '{1, mkpos(1, 2, 3), 1'b1, 8'h11};
        vecs[4] = '{1, mkpos(1, 2, 3), 1'b0, 8'h11};
        vecs[5] = '{3, mkpos(0, 0, 0), 1'b1, 8'h22};
        vecs[6] = '{1, mkpos(1, 2, 3), 1'b1, 8'h33};
        vecs[7] = '{2, mkpos(255, 255, 255), 1'b1, 8'h44};
        vecs[8] = '{2, mkpos(255, 255, 255), 1'b0, 8'h44};

        rst_in         = 1'b1;
        req_valid      = '0;
        req_pos        = '0;
        fill_req_ready = 1'b1;
        fill_rsp_valid = 1'b0;
        fill_rsp_type  = '0;
        repeat (3) @(negedge clk);
        rst_in = 1'b0;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_type", rsp_type, 0);
        check("reset_fill_valid", fill_req_valid, 0);
        check("reset_fill_pos", fill_req_pos, 0);
`ifdef BLOCK_CACHE_MP_STATS_EN
        check("reset_hit_count", hit_count, 0);
        check("reset_miss_count", miss_count, 0);
`endif

        for (int i = 0; i < 9; i++) begin
            do_lookup(vecs[i]);
`ifdef BLOCK_CACHE_MP_STATS_EN
            if (i == 1) begin
                check("stats_hit", hit_count, 1);
                check("stats_miss", miss_count, 1);
            end
`endif
        end

        // Shared miss: two ports, one position, one fill
        p = mkpos(10, 0, 10);
        base = fill_issues;
        req_pos[1] = p;
        req_pos[3] = p;
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        @(negedge clk);
        serve_fill(8'h5C, 2, got);
        check("shared_pos", got, p);
        check("shared_both_valid", {rsp_valid[1], rsp_valid[3]}, 2'b11);
        check("shared_type1", rsp_type[1], 8'h5C);
        check("shared_type3", rsp_type[3], 8'h5C);
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("shared_one_fill", fill_issues - base, 1);

        // Conflict: same index, different tags, served in rr order
        base = fill_issues;
        req_pos[0] = mkpos(1, 0, 0);
        req_pos[1] = mkpos(0, 1, 0);
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        @(negedge clk);
        serve_fill(8'h61, 1, got);
        check("conflict_first_pos", got, mkpos(1, 0, 0));
        check("conflict_p0_valid", rsp_valid[0], 1);
        check("conflict_p1_waits", rsp_valid[1], 0);
        check("conflict_p0_type", rsp_type[0], 8'h61);
        req_valid[0] = 1'b0;
        serve_fill(8'h62, 1, got);
        check("conflict_second_pos", got, mkpos(0, 1, 0));
        check("conflict_p1_valid", rsp_valid[1], 1);
        check("conflict_p1_type", rsp_type[1], 8'h62);
        req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("conflict_two_fills", fill_issues - base, 2);

        // Backpressure, then reset while the fill is outstanding
        p = mkpos(7, 7, 7);
        fill_req_ready = 1'b0;
        req_pos[2] = p;
        req_valid[2] = 1'b1;
        repeat (2) @(negedge clk);
        check("bp_fill_valid", fill_req_valid, 1);
        repeat (10) begin
            @(negedge clk);
            check("bp_pos_stable", {fill_req_valid, fill_req_pos}, {1'b1, p});
        end
        fill_req_ready = 1'b1;
        @(negedge clk);
        rst_in = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst_in = 1'b0;
        fill_rsp_valid = 1'b1;
        fill_rsp_type  = 8'h77;
        @(negedge clk);
        fill_rsp_valid = 1'b0;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_type", rsp_type, 0);
        check("rst_fill_valid", fill_req_valid, 0);
        check("rst_fill_pos", fill_req_pos, 0);
`ifdef BLOCK_CACHE_MP_STATS_EN
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
`endif
        @(negedge clk);
        do_lookup('{2, p, 1'b1, 8'h78});
        do_lookup('{0, mkpos(3, 5, 7), 1'b1, 8'h2B});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/block_cache_mp.md
Name: block_cache_mp

Overview:
- Parametrised multi-port, direct-mapped block cache. Maps a BlockPos to its BlockType for NUM_PORTS independent lookup ports.
- Successor to the fixed 4-port L2 lookup: configurable port count and depth.
- Adds a miss-refill handshake to the world-memory backend.
- Per-port request/response handshake replaces the free-running valid.

Parameters:
- NUM_PORTS, 4: number of independent lookup ports (1..8).
- NUM_LINES, 64: cache lines; power of two, 8..256.
- IDX_W, $clog2(NUM_LINES): index width; localparam, not overridable.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- req_valid  input  NUM_PORTS  per-port lookup request
- req_pos  input  NUM_PORTS x BlockPos  per-port queried position
- rsp_valid  output  NUM_PORTS  one-cycle response pulse per port
- rsp_type  output  NUM_PORTS x BlockType  looked-up block; valid only with rsp_valid
- fill_req_valid  output  1  refill request to backend
- fill_req_ready  input  1  backend accepts refill request
- fill_req_pos  output  BlockPos  position to fetch
- fill_rsp_valid  input  1  backend returns data (single-cycle pulse)
- fill_rsp_type  input  BlockType  fetched block

Behaviour:
- Clock and reset:
  - Single clock domain: clk_in.
  - rst_in is synchronous and active-high.
- Storage:
  - Flop array per line: {line_valid, tag: BlockPos, data: BlockType}.
  - index = (pos.x ^ pos.y ^ pos.z)[IDX_W-1:0].
  - Tag is the full BlockPos.
- Port handshake:
  - A port raises req_valid and holds req_pos stable until it sees its rsp_valid pulse.
  - The next request may be presented in the cycle after the pulse.
  - Changing req_pos while a request is pending is illegal. A bench assertion checks this.
- Hit:
  - Registered lookup; rsp_valid is asserted exactly 1 cycle after req_valid is sampled.
  - A back-to-back re-request therefore yields one response per 2 cycles per port.
- Miss:
  - The port enters PENDING.
  - Round-robin arbiter picks the lowest pending port at or after the rr pointer.
  - rr pointer advances past the winner on each issued fill.
- Fill FSM:
  - IDLE -> ISSUE when any port is PENDING. Latch fill_req_pos.
  - ISSUE: fill_req_valid=1, fill_req_pos held. ISSUE -> WAIT on fill_req_valid && fill_req_ready.
  - WAIT -> IDLE on fill_rsp_valid. The line at index(fill_req_pos) is written {1, fill_req_pos, fill_rsp_type}, evicting unconditionally.
  - One fill is outstanding at most.
- Fill completion:
  - Every PENDING port whose req_pos equals fill_req_pos gets rsp_valid with rsp_type = fill_rsp_type in the cycle after fill_rsp_valid. Forwarded; no re-lookup.
  - Other PENDING ports stay pending and re-arbitrate from IDLE.
- Simultaneous events:
  - A lookup in the same cycle as a fill write sees pre-write contents. If that lookup misses on the position being filled, it is caught by the forward-match rule (same position compare).
  - Two pending ports mapping to the same index with different tags are served sequentially. Thrashing is allowed; forward progress is guaranteed by the per-fill forward.
- fill_rsp_valid outside WAIT is ignored.
- Reset values:
  - rsp_valid=0, rsp_type=0.
  - fill_req_valid=0, fill_req_pos=0.
  - All line_valid=0.
  - All ports IDLE; rr pointer=0; FSM=IDLE.
- Reset mid-fill: the outstanding request is abandoned, and a late fill_rsp_valid is ignored.

Optional Feature:
- Macro: BLOCK_CACHE_MP_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0].
  - Each counts per-port lookup outcomes; multiple ports in one cycle add their count.
  - Counters saturate at 32'hFFFF_FFFF.
  - Cleared by rst_in.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared types package (types.sv): BlockPos (fields x, y, z) and BlockType.
- Add to the same package:
  - the index-hash function block_index(pos, idx_w);
  - localparam MAX_CACHE_PORTS=8.
- One sub-module: rr_arbiter (parameter N; inputs req[N], advance; output one-hot grant[N] and grant_idx).

Test Plan:
- Cold miss:
  - Stimulus: after reset, port0 requests pos (3,5,7); backend ready=1, responds with type 0x2A after 4 cycles.
  - Required: exactly one fill_req with pos (3,5,7); port0 rsp_valid 1 cycle after fill_rsp_valid, rsp_type=0x2A.
- Warm hit:
  - Stimulus: port0 re-requests (3,5,7).
  - Required: rsp_valid next cycle, type 0x2A, no fill_req.
- Shared miss:
  - Stimulus: ports 1 and 3 request (10,0,10) in the same cycle.
  - Required: a single fill; both rsp_valid in the same cycle with identical type.
- Conflict:
  - Stimulus: (1,0,0) and (0,1,0) share index 1; ports 0 and 1 miss together.
  - Required: two sequential fills, port 0 first (rr=0); both eventually respond with correct types.
- Backpressure and reset:
  - Stimulus: hold fill_req_ready=0 for 10 cycles, then assert rst_in during WAIT.
  - Required: fill_req_pos stable while stalled; after reset all outputs 0, a late fill_rsp_valid is ignored, and a subsequent lookup misses.
- Stats (with BLOCK_CACHE_MP_STATS_EN defined):
  - Stimulus: run the warm-hit scenario.
  - Required: miss_count=1, hit_count=1.
